// File: rtl/reg_mem_pkg.sv
// Shared types and default sizes for the reg_mem BIST sweep engine.
package reg_mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_CHK  = 3'd3,
    DONE    = 3'd4
  } bist_state_e;

endpackage

// File: rtl/reg_mem_bist.sv
// Write/read-back BIST for a reg_mem port: writes seed+addr everywhere, then checks it.
// Optional first-failure log enabled by defining REG_MEM_BIST_ERRLOG_EN.
module reg_mem_bist
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_BITS:0]    err_count,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef REG_MEM_BIST_ERRLOG_EN
  ,
  output logic [ADDR_BITS-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  fail_vld
`endif
);

  localparam logic [ADDR_BITS-1:0] CNT_LAST = '1;
  localparam logic [ADDR_BITS-1:0] CNT_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   ERR_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   ERR_MAX  = {1'b1, {ADDR_BITS{1'b0}}};

  bist_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0]  cnt_q, cnt_d, cnt_nxt;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [DATA_WIDTH-1:0] exp_cur, exp_nxt;
  logic [ADDR_BITS:0]    err_d;
  logic [ADDR_BITS-1:0]  addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  busy_d, done_d, pass_d, wen_d;
  logic                  start_acc, mismatch;

  assign cnt_nxt   = cnt_q + CNT_ONE;
  assign exp_cur   = seed_q + DATA_WIDTH'(cnt_q);
  assign exp_nxt   = seed_q + DATA_WIDTH'(cnt_nxt);
  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  assign mismatch  = (state_q == RD_CHK) && (mem_rdata != exp_cur);

  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    err_d   = err_count;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    wen_d   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          seed_d  = seed;
          err_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          addr_d  = '0;
          wdata_d = seed;
          wen_d   = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          addr_d  = '0;
          state_d = RD_ADDR;
        end else begin
          cnt_d   = cnt_nxt;
          addr_d  = cnt_nxt;
          wdata_d = exp_nxt;
          wen_d   = 1'b1;
        end
      end
      RD_ADDR: begin
        addr_d  = cnt_q;
        state_d = RD_CHK;
      end
      RD_CHK: begin
        if (mismatch && (err_count != ERR_MAX)) err_d = err_count + ERR_ONE;
        if (cnt_q == CNT_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = DONE;
        end else begin
          cnt_d   = cnt_nxt;
          addr_d  = cnt_nxt;
          state_d = RD_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      seed_q    <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      err_count <= err_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_wen   <= wen_d;
    end
  end

`ifdef REG_MEM_BIST_ERRLOG_EN
  // Only the first mismatch of a sweep is kept; later ones just count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vld  <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (start_acc) begin
      fail_vld  <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (mismatch && !fail_vld) begin
      fail_vld  <= 1'b1;
      fail_addr <= cnt_q;
      fail_data <= mem_rdata;
    end
  end
`else
  // Without the log, start_acc has no consumer beyond the FSM decode.
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_reg_mem_bist.sv
// Self-checking bench for reg_mem_bist with a behavioural reg_mem and fault injection.
module tb_reg_mem_bist;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] seed  = '0;
  logic          busy, done, pass, mem_wen;
  logic [AW:0]   err_count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef REG_MEM_BIST_ERRLOG_EN
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic          fail_vld;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [DEPTH-1:0] fault_mask = '0;
  logic [DW-1:0]    mem [DEPTH];

  reg_mem_bist #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
`ifdef REG_MEM_BIST_ERRLOG_EN
    ,
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .fail_vld  (fail_vld)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural reg_mem: synchronous write, asynchronous read, optional bit0 fault.
  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr] ^ {{(DW-1){1'b0}}, fault_mask[mem_addr]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full sweep; expected results come from the caller's model/table.
  task automatic run_sweep(input logic [DW-1:0] s, input logic [DEPTH-1:0] m,
                           input int restart_at, input logic [AW:0] exp_err,
                           input logic exp_pass);
    int lat;
    int bad;
    logic [DW-1:0] e;
    fault_mask = m;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("accept_busy", 32'(busy), 1);
    check("accept_done_clr", 32'(done), 0);
    check("accept_err_clr", 32'(err_count), 0);
    check("first_write", {mem_wen, mem_addr, mem_wdata}, {1'b1, 5'd0, s});
    seed = s ^ 8'h5A;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      start = (k == restart_at);
    end
    start = 1'b0;
    check("done_latency", lat, 3 * DEPTH);
    check("err_count", 32'(err_count), 32'(exp_err));
    check("pass", 32'(pass), 32'(exp_pass));
    check("busy_low", 32'(busy), 0);
    check("wen_low", 32'(mem_wen), 0);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      e = s + DW'(a);
      if (mem[a] !== e) bad++;
    end
    check("mem_image", bad, 0);
`ifdef REG_MEM_BIST_ERRLOG_EN
    check("fail_vld", 32'(fail_vld), 32'(m != 0));
    for (int a = 0; a < DEPTH; a++) begin
      if (m[a]) begin
        e = (s + DW'(a)) ^ 8'h01;
        check("fail_addr", 32'(fail_addr), a);
        check("fail_data", 32'(fail_data), 32'(e));
        break;
      end
    end
`endif
  endtask

  typedef struct {
    logic [DW-1:0]    seed;
    logic [DEPTH-1:0] mask;
    int               restart_at;
    logic [AW:0]      exp_err;
    logic             exp_pass;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [DW-1:0]    rs;
    logic [DEPTH-1:0] rm;

    vecs[0] = '{8'd10,  32'h0000_0000, 0,  6'd0,  1'b1};
    vecs[1] = '{8'hF0,  32'h0000_0000, 0,  6'd0,  1'b1};
    vecs[2] = '{8'h20,  32'h0000_0080, 0,  6'd1,  1'b0};
    vecs[3] = '{8'd3,   32'h0000_0000, 0,  6'd0,  1'b1};
    vecs[4] = '{8'h81,  32'h0000_0000, 20, 6'd0,  1'b1};
    vecs[5] = '{8'hC4,  32'h8000_0001, 0,  6'd2,  1'b0};
    vecs[6] = '{8'h11,  32'hFFFF_FFFF, 0,  6'd32, 1'b0};

    #12;
    check("reset_outputs", {busy, done, pass, mem_wen, err_count, mem_addr, mem_wdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_sweep(vecs[i].seed, vecs[i].mask, vecs[i].restart_at,
                vecs[i].exp_err, vecs[i].exp_pass);
      if (i == 1) begin
        check("wrap_addr15", 32'(mem[15]), 32'h0000_00FF);
        check("wrap_addr16", 32'(mem[16]), 32'h0000_0000);
        check("wrap_addr31", 32'(mem[31]), 32'h0000_000F);
      end
    end

    // Reset in the middle of the write phase aborts everything.
    fault_mask = '0;
    @(negedge clk);
    seed  = 8'h4C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("pre_reset_addr", 32'(mem_addr), 12);
    check("pre_reset_wen", 32'(mem_wen), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {busy, done, pass, mem_wen, err_count, mem_addr, mem_wdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(8'h4C, '0, 0, 6'd0, 1'b1);

    // Randomised sweeps against the counting model.
    for (int r = 0; r < 4; r++) begin
      rs = DW'($urandom);
      rm = DEPTH'($urandom & $urandom & $urandom);
      run_sweep(rs, rm, 0, (AW+1)'($countones(rm)), rm == '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
